iterative_comparator: RTL and testbench

Parametrised, multi-cycle magnitude/equality comparator for the Tiny-CPU datapath, the successor to the fixed 8-bit combinational greater-or-equal comparator. It compares two WIDTH-bit operands MSB-first, SLICE bits per cycle, with early termination on the first differing slice. It supports signed/unsigned and six predicates, and returns an all-ones/all-zeros mask plus relation flags over a valid/ready handshake. It sits between the register file and the branch/ALU result mux.

---
 rtl/iterative_comparator.sv | 166 ++++++++++++++++
 tb/tb_iterative_comparator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_comparator.sv
// Multi-cycle magnitude/equality comparator.
// Operands are compared MSB-first, SLICE bits per cycle. The FSM stops on the
// first differing slice. The result is returned as an all-ones/all-zeros mask
// plus eq/lt/gt relation flags, over a valid/ready handshake.
module iterative_comparator #(
  parameter int WIDTH     = 8,
  parameter int SLICE     = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [WIDTH-1:0]     comparator_input1,
  input  logic [WIDTH-1:0]     comparator_input2,
  input  logic [2:0]           mode,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [OUT_WIDTH-1:0] result_mask,
  output logic                 flag_eq,
  output logic                 flag_lt,
  output logic                 flag_gt,
  output logic                 busy
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  // Predicate encodings
  localparam logic [2:0] M_GEU = 3'b000;
  localparam logic [2:0] M_LTU = 3'b001;
  localparam logic [2:0] M_GES = 3'b010;
  localparam logic [2:0] M_LTS = 3'b011;
  localparam logic [2:0] M_EQ  = 3'b100;
  localparam logic [2:0] M_NE  = 3'b101;
  localparam logic [2:0] M_GTU = 3'b110;
  localparam logic [2:0] M_LEU = 3'b111;

  // A slice split that does not tile the operand exactly is a configuration error
  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_params
      $error("iterative_comparator: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [2:0]             r_mode;
  logic [CNT_W-1:0]       r_cnt;
  logic [OUT_WIDTH-1:0]   r_mask;
  logic                   r_eq;
  logic                   r_lt;
  logic                   r_gt;

  logic                   w_accept;
  logic                   w_signed_mode;
  logic [WIDTH-1:0]       w_msb_flip;
  logic [SLICE-1:0]       w_a_sl [N];
  logic [SLICE-1:0]       w_b_sl [N];
  logic [SLICE-1:0]       w_a_cur;
  logic [SLICE-1:0]       w_b_cur;
  logic                   w_slice_gt;
  logic                   w_slice_lt;
  logic                   w_last;
  logic                   w_enter_done;
  logic                   w_pred;

  // Slice 0 holds the most significant bits, so the count walks MSB to LSB
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slices
      assign w_a_sl[gi] = r_a[WIDTH-1-gi*SLICE -: SLICE];
      assign w_b_sl[gi] = r_b[WIDTH-1-gi*SLICE -: SLICE];
    end
  endgenerate

  assign w_a_cur = w_a_sl[r_cnt];
  assign w_b_cur = w_b_sl[r_cnt];

  // Flipping the sign bit of both operands maps two's complement order onto unsigned order
  assign w_signed_mode = (mode == M_GES) || (mode == M_LTS);
  assign w_msb_flip    = {w_signed_mode, {(WIDTH-1){1'b0}}};
  assign w_accept      = start_valid && (r_state == S_IDLE);

  // Current-slice relation, next state, and the predicate for the decided relation
  always_comb begin
    w_state_next = r_state;
    w_slice_gt   = (w_a_cur > w_b_cur);
    w_slice_lt   = (w_a_cur < w_b_cur);
    w_last       = (r_cnt == LAST_CNT);
    w_enter_done = 1'b0;
    w_pred       = 1'b0;

    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_RUN;
      S_RUN: begin
        if (w_slice_gt || w_slice_lt || w_last) begin
          w_state_next = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      S_DONE: if (result_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Equality is implied when the decision comes from the final slice with no difference
    case (r_mode)
      M_GEU, M_GES: w_pred = !w_slice_lt;
      M_LTU, M_LTS: w_pred = w_slice_lt;
      M_EQ:         w_pred = !w_slice_gt && !w_slice_lt;
      M_NE:         w_pred = w_slice_gt || w_slice_lt;
      M_GTU:        w_pred = w_slice_gt;
      M_LEU:        w_pred = !w_slice_gt;
      default:      w_pred = 1'b0;
    endcase
  end

  // State register; reset discards any request in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Operand latch, slice counter, and result capture on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mode <= '0;
      r_cnt  <= '0;
      r_mask <= '0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
      r_gt   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= comparator_input1 ^ w_msb_flip;
        r_b    <= comparator_input2 ^ w_msb_flip;
        r_mode <= mode;
        r_cnt  <= '0;
      end else if ((r_state == S_RUN) && !w_enter_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_enter_done) begin
        r_mask <= {OUT_WIDTH{w_pred}};
        r_gt   <= w_slice_gt;
        r_lt   <= w_slice_lt;
        r_eq   <= !w_slice_gt && !w_slice_lt;
      end
    end
  end

  assign start_ready  = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign result_valid = (r_state == S_DONE);
  assign result_mask  = r_mask;
  assign flag_eq      = r_eq;
  assign flag_lt      = r_lt;
  assign flag_gt      = r_gt;

endmodule

// File: tb/tb_iterative_comparator.sv
// Bench for iterative_comparator: directed test-plan steps plus random requests,
// checked against an arithmetic reference model, on an 8/2 and a 16/4 instance.
module tb_iterative_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance signals
  logic       sv8 = 1'b0, rr8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] m8 = '0;
  logic       sr8, rv8, eq8, lt8, gt8, busy8;
  logic [7:0] mask8;

  // 16-bit instance signals
  logic        sv16 = 1'b0, rr16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [2:0]  m16 = '0;
  logic        sr16, rv16, eq16, lt16, gt16, busy16;
  logic [15:0] mask16;

  iterative_comparator #(.WIDTH(8), .SLICE(2), .OUT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .comparator_input1(a8), .comparator_input2(b8), .mode(m8),
    .result_valid(rv8), .result_ready(rr8), .result_mask(mask8),
    .flag_eq(eq8), .flag_lt(lt8), .flag_gt(gt8), .busy(busy8)
  );

  iterative_comparator #(.WIDTH(16), .SLICE(4), .OUT_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(sr16),
    .comparator_input1(a16), .comparator_input2(b16), .mode(m16),
    .result_valid(rv16), .result_ready(rr16), .result_mask(mask16),
    .flag_eq(eq16), .flag_lt(lt16), .flag_gt(gt16), .busy(busy16)
  );

  // Selected-instance view used by the shared tasks
  logic        sel16 = 1'b0;
  logic        o_sr, o_rv, o_busy;
  logic [15:0] o_mask;
  logic [2:0]  o_flags;
  assign o_sr    = sel16 ? sr16 : sr8;
  assign o_rv    = sel16 ? rv16 : rv8;
  assign o_busy  = sel16 ? busy16 : busy8;
  assign o_mask  = sel16 ? mask16 : {8'h00, mask8};
  assign o_flags = sel16 ? {gt16, lt16, eq16} : {gt8, lt8, eq8};

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: relation from integer comparison, latency from the highest differing bit
  task automatic model(input bit wide, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] m, output logic [15:0] exp_mask,
                       output logic [2:0] exp_flags, output int exp_lat);
    int w, s, n, ia, ib, rel, p;
    bit pred;
    logic [15:0] diff;
    w = wide ? 16 : 8;
    s = wide ? 4 : 2;
    n = w / s;
    ia = wide ? int'(a) : int'(a[7:0]);
    ib = wide ? int'(b) : int'(b[7:0]);
    if (m == 3'd2 || m == 3'd3) begin
      if (ia >= (1 << (w - 1))) ia -= (1 << w);
      if (ib >= (1 << (w - 1))) ib -= (1 << w);
    end
    rel = (ia > ib) ? 1 : ((ia < ib) ? -1 : 0);
    case (m)
      3'd0, 3'd2: pred = (rel >= 0);
      3'd1, 3'd3: pred = (rel < 0);
      3'd4:       pred = (rel == 0);
      3'd5:       pred = (rel != 0);
      3'd6:       pred = (rel > 0);
      default:    pred = (rel <= 0);
    endcase
    exp_mask  = pred ? (wide ? 16'hFFFF : 16'h00FF) : 16'h0000;
    exp_flags = (rel > 0) ? 3'b100 : ((rel < 0) ? 3'b010 : 3'b001);
    diff = (a ^ b) & (wide ? 16'hFFFF : 16'h00FF);
    if (diff == 0) exp_lat = n;
    else begin
      p = 0;
      for (int i = 0; i < w; i++) if (diff[i]) p = i;
      exp_lat = (w - 1 - p) / s + 1;
    end
  endtask

  task automatic drive(input bit wide, input logic sv, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] m);
    if (wide) begin sv16 = sv; a16 = a; b16 = b; m16 = m; end
    else      begin sv8 = sv;  a8 = a[7:0]; b8 = b[7:0]; m8 = m; end
  endtask

  task automatic set_rr(input bit wide, input logic v);
    if (wide) rr16 = v; else rr8 = v;
  endtask

  // One request; optional hold of result_ready low with start_valid poked meanwhile
  task automatic run(input bit wide, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] m, input int hold, input bit poke,
                     input int lat_c, input int mask_c);
    logic [15:0] e_mask, s_mask;
    logic [2:0]  e_flags, s_flags;
    int e_lat, k;
    model(wide, a, b, m, e_mask, e_flags, e_lat);
    sel16 = wide;
    @(negedge clk);
    drive(wide, 1'b1, a, b, m);
    chk("ready_before_accept", o_sr, 1);
    @(posedge clk); #1;
    drive(wide, 1'b0, 16'($urandom), 16'($urandom), 3'($urandom));
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!o_rv && k < 20);
    $display("req w=%0d a=%h b=%h mode=%0d lat=%0d mask=%h flags=%b",
             wide ? 16 : 8, a, b, m, k, o_mask, o_flags);
    chk("latency", k, e_lat);
    chk("mask", o_mask, e_mask);
    chk("flags", o_flags, e_flags);
    if (lat_c >= 0)  chk("latency_plan", k, lat_c);
    if (mask_c >= 0) chk("mask_plan", o_mask, mask_c);
    s_mask = o_mask;
    s_flags = o_flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (poke) drive(wide, 1'b1, 16'($urandom), 16'($urandom), 3'($urandom));
      chk("bp_valid", o_rv, 1);
      chk("bp_mask", o_mask, s_mask);
      chk("bp_flags", o_flags, s_flags);
      chk("bp_start_ready", o_sr, 0);
    end
    @(negedge clk);
    drive(wide, 1'b0, 16'h0, 16'h0, 3'd0);
    set_rr(wide, 1'b1);
    @(posedge clk); #1;
    set_rr(wide, 1'b0);
    chk("ready_after_hs", o_sr, 1);
    chk("valid_after_hs", o_rv, 0);
    if (poke) begin
      repeat (5) @(posedge clk);
      #1;
      chk("no_extra_request", o_busy, 0);
    end
  endtask

  logic [15:0] ra, rb;
  bit          seen;

  initial begin
    // Reset state
    sel16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", o_sr, 1);
    chk("rst_valid", o_rv, 0);
    chk("rst_mask", o_mask, 0);
    chk("rst_flags", o_flags, 0);
    chk("rst_busy", o_busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // Legacy equivalence, early exit/signedness, late difference
    run(0, 16'h05, 16'h05, 3'd0, 0, 0, 4, 'hFF);
    run(0, 16'h80, 16'h7F, 3'd0, 0, 0, 1, 'hFF);
    run(0, 16'h80, 16'h7F, 3'd2, 0, 0, 1, 'h00);
    chk("ges_flag_lt", o_flags, 3'b010);
    run(0, 16'h34, 16'h37, 3'd1, 0, 0, 4, 'hFF);
    run(0, 16'h34, 16'h37, 3'd4, 0, 0, 4, 'h00);
    run(0, 16'h34, 16'h37, 3'd5, 0, 0, 4, 'hFF);

    // Reset mid-RUN at cnt=1 of an EQ on equal operands
    sel16 = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 16'h5A, 16'h5A, 3'd4);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 3'd0);
    @(posedge clk); #3;
    chk("mid_run_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", o_sr, 1);
    chk("mid_rst_valid", o_rv, 0);
    chk("mid_rst_mask", o_mask, 0);
    chk("mid_rst_flags", o_flags, 0);
    chk("mid_rst_busy", o_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= o_rv;
    end
    chk("no_result_after_rst", seen, 0);
    run(0, 16'h12, 16'h13, 3'd7, 0, 0, 4, 'hFF);

    // Backpressure with start_valid pulsed while DONE
    run(0, 16'hC3, 16'hC1, 3'd6, 5, 1, 4, 'hFF);

    // Wider configuration
    run(1, 16'hFFFF, 16'h0001, 3'd6, 0, 0, 1, 'hFFFF);
    run(1, 16'hFFFF, 16'h0001, 3'd2, 0, 0, 1, 'h0000);
    chk("w16_ges_flag_lt", o_flags, 3'b010);
    run(1, 16'h1234, 16'h1234, 3'd7, 0, 0, 4, 'hFFFF);

    // Random requests on both instances, biased toward near-equal operands
    for (int t = 0; t < 40; t++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = ra;
      endcase
      run(bit'($urandom_range(0, 1)), ra, rb, 3'($urandom), $urandom_range(0, 2), 0, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
